// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_pkg;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;
  localparam int FIFO_DEPTH = 8;
  localparam int BYTE_W     = 8;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester lanes plus FIFO write side; master = arbiter, slave = requesters/FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import fifo_pkg::*;
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][BYTE_W-1:0] req_data;
  logic [NREQ-1:0]             req_last;
  logic [NREQ-1:0]             gnt;
  logic                        fifo_full;
  logic                        fifo_wr;
  logic [BYTE_W-1:0]           fifo_data;
  logic                        busy;
  logic [IDW-1:0]              owner;

  modport master (input req, req_data, req_last, fifo_full,
                  output gnt, fifo_wr, fifo_data, busy, owner);
  modport slave  (output req, req_data, req_last, fifo_full,
                  input gnt, fifo_wr, fifo_data, busy, owner);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module fifo_wr_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  win_o,
  output logic            any_o
);
  logic [IDW-1:0] idx;

  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        win_o = idx;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NREQ byte requesters.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int IDW       = 2
) (
  input logic                clk,
  input logic                reset_n,
  fifo_wr_arbiter_if.master  bus
);
  localparam int BCW = $clog2(MAX_BURST) + 1;

  arb_state_t     state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] owner_q;
  logic [BCW-1:0] beat_q;

  logic [IDW-1:0] pick;
  logic           any_req;
  logic           in_burst, own_req, accept, last_beat, burst_end;

  fifo_wr_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .win_o (pick),
    .any_o (any_req)
  );

  assign in_burst  = (state_q == BURST);
  assign own_req   = bus.req[owner_q];
  assign accept    = in_burst & own_req & ~bus.fifo_full;
  assign last_beat = bus.req_last[owner_q] | (beat_q == BCW'(MAX_BURST - 1));
  // A full stall is not an end; only last/limit on an accepted beat, or a withdraw.
  assign burst_end = in_burst & ((accept & last_beat) | ~own_req);

  always_comb begin
    bus.gnt          = '0;
    bus.gnt[owner_q] = accept;
  end

  assign bus.fifo_wr   = accept;
  assign bus.fifo_data = accept ? bus.req_data[owner_q] : '0;
  assign bus.busy      = in_burst;
  assign bus.owner     = owner_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          owner_q <= pick;
          beat_q  <= '0;
          state_q <= BURST;
        end
        BURST: begin
          if (burst_end) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            rr_ptr_q <= (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          end else if (accept) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: lane byte queues drive requesters, expected writes are queued and popped per write.
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;
  localparam int NREQ = 4, MAX_BURST = 4, IDW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .IDW(IDW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]     d;
    logic [IDW-1:0] o;
  } exp_t;

  exp_t            expq[$];
  exp_t            mon_e;
  logic [8:0]      lmem [NREQ][32];
  int              lhd  [NREQ];
  int              ltl  [NREQ];
  logic [NREQ-1:0] gnt_seen = '0;
  int              cyc = 0, wr_n = 0;
  int              wr_cyc [128];
  int              n_tot = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_lane(input int l, input logic [7:0] d, input logic lst);
    lmem[l][ltl[l]] = {lst, d};
    ltl[l]++;
  endtask

  task automatic expect_wr(input logic [7:0] d, input int o);
    exp_t e;
    e.d = d;
    e.o = IDW'(o);
    expq.push_back(e);
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while (expq.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(expq.size()), 32'd0);
  endtask

  always @(posedge clk) cyc++;

  // requester model: consume the byte granted at this edge, then present the next one
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_seen[i] && lhd[i] < ltl[i]) lhd[i]++;
      bus.req[i]      = (lhd[i] < ltl[i]);
      bus.req_data[i] = (lhd[i] < ltl[i]) ? lmem[i][lhd[i]][7:0] : 8'h00;
      bus.req_last[i] = (lhd[i] < ltl[i]) ? lmem[i][lhd[i]][8]   : 1'b0;
    end
  end

  // write monitor / scoreboard
  always @(negedge clk) begin
    gnt_seen = bus.gnt;
    if (reset_n) begin
      if (bus.fifo_wr) begin
        if (wr_n < 128) wr_cyc[wr_n] = cyc;
        wr_n++;
        if (expq.size() == 0) begin
          chk("wr_expected", 32'(expq.size()), 32'd1);
        end else begin
          mon_e = expq.pop_front();
          chk("wr_data",  32'(bus.fifo_data), 32'(mon_e.d));
          chk("wr_owner", 32'(bus.owner),     32'(mon_e.o));
          chk("wr_gnt",   32'(bus.gnt),       32'(4'b0001 << mon_e.o));
        end
      end else begin
        chk("idle_gnt",  32'(bus.gnt),       32'd0);
        chk("idle_data", 32'(bus.fifo_data), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit found;
    bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin lhd[i] = 0; ltl[i] = 0; end

    // all four lanes busy, no last: 4 beats each, lane 0 gets a second turn
    for (int l = 0; l < NREQ; l++)
      for (int j = 0; j < 4; j++) begin
        push_lane(l, 8'((l + 1) * 16 + j), 1'b0);
        expect_wr(8'((l + 1) * 16 + j), l);
      end
    for (int j = 4; j < 8; j++) begin
      push_lane(0, 8'(16 + j), 1'b0);
      expect_wr(8'(16 + j), 0);
    end

    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt",   32'(bus.gnt),     32'd0);
      chk("rst_wr",    32'(bus.fifo_wr), 32'd0);
      chk("rst_busy",  32'(bus.busy),    32'd0);
      chk("rst_owner", 32'(bus.owner),   32'd0);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    @(negedge clk);
    chk("arb_cycle_gnt",  32'(bus.gnt),  32'd0);
    chk("arb_cycle_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("first_gnt",   32'(bus.gnt),   32'd1);
    chk("first_owner", 32'(bus.owner), 32'd0);
    wait_drain(200);
    chk("rot_span",    32'(wr_cyc[19] - wr_cyc[0]), 32'd23);
    chk("rot_inburst", 32'(wr_cyc[3] - wr_cyc[0]),  32'd3);
    chk("rot_gap",     32'(wr_cyc[4] - wr_cyc[3]),  32'd2);
    repeat (3) @(negedge clk);
    chk("rot_idle", 32'(bus.busy), 32'd0);

    // lane 2 alone, last on second byte; then 3 and 0 together prove rr_ptr=3
    push_lane(2, 8'hA1, 1'b0); push_lane(2, 8'hA2, 1'b1);
    expect_wr(8'hA1, 2); expect_wr(8'hA2, 2);
    wait_drain(50);
    repeat (3) @(negedge clk);
    chk("last_idle",  32'(bus.busy),  32'd0);
    chk("last_owner", 32'(bus.owner), 32'd2);
    push_lane(3, 8'hB3, 1'b1); push_lane(0, 8'hB0, 1'b1);
    expect_wr(8'hB3, 3); expect_wr(8'hB0, 0);
    wait_drain(50);

    // full stall after 3 beats of owner 1
    repeat (3) @(negedge clk);
    base = wr_n;
    for (int j = 0; j < 8; j++) begin
      push_lane(1, 8'(8'h50 + j), 1'b0);
      expect_wr(8'(8'h50 + j), 1);
    end
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (wr_n == base + 3) found = 1;
    end
    chk("full_reach3", 32'(wr_n), 32'(base + 3));
    bus.fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("full_gnt",   32'(bus.gnt),     32'd0);
      chk("full_wr",    32'(bus.fifo_wr), 32'd0);
      chk("full_owner", 32'(bus.owner),   32'd1);
      chk("full_busy",  32'(bus.busy),    32'd1);
    end
    @(posedge clk); #1 bus.fifo_full = 1'b0;
    wait_drain(100);
    chk("full_stall_gap", 32'(wr_cyc[base + 3] - wr_cyc[base + 2]), 32'd6);
    chk("full_end_gap",   32'(wr_cyc[base + 4] - wr_cyc[base + 3]), 32'd2);

    // owner 3 withdraws after one beat; 0 and 2 queued meanwhile, wrap to 0
    repeat (3) @(negedge clk);
    base = wr_n;
    push_lane(3, 8'h60, 1'b0);
    expect_wr(8'h60, 3); expect_wr(8'h70, 0); expect_wr(8'h72, 2);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (bus.busy && bus.owner == 2'd3) found = 1;
    end
    chk("wd_owner3", 32'(bus.owner), 32'd3);
    push_lane(0, 8'h70, 1'b1); push_lane(2, 8'h72, 1'b1);
    wait_drain(50);
    chk("wd_gap", 32'(wr_cyc[base + 1] - wr_cyc[base]), 32'd3);

    // reset pulse during beat 2 of owner 1
    repeat (3) @(negedge clk);
    base = wr_n;
    for (int j = 0; j < 4; j++) push_lane(1, 8'(8'h80 + j), 1'b0);
    expect_wr(8'h80, 1);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk); #2;
      if (wr_n == base + 1) found = 1;
    end
    chk("rst_reach1", 32'(wr_n), 32'(base + 1));
    #1 reset_n = 1'b0;
    #1;
    chk("arst_gnt",   32'(bus.gnt),       32'd0);
    chk("arst_wr",    32'(bus.fifo_wr),   32'd0);
    chk("arst_data",  32'(bus.fifo_data), 32'd0);
    chk("arst_busy",  32'(bus.busy),      32'd0);
    chk("arst_owner", 32'(bus.owner),     32'd0);
    push_lane(3, 8'h93, 1'b1);
    expect_wr(8'h81, 1); expect_wr(8'h82, 1); expect_wr(8'h83, 1); expect_wr(8'h93, 3);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    chk("prst_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("prst_pick", 32'(bus.owner), 32'd1);
    chk("prst_busy", 32'(bus.busy),  32'd1);
    wait_drain(100);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
